// File: rtl/ast_alert_sender_pkg.sv
// ============================================================================
// Module   : my_pkg
// Brief    : Shared AST alert types and the alert-sender channel state enum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package my_pkg;

    localparam int AST_ALERTS = 2;

    typedef struct packed {
        logic p;
    } ast_dif_t;

    typedef struct packed {
        ast_dif_t [AST_ALERTS-1:0] alerts_ack;
    } ast_alert_rsp_t;

    typedef struct packed {
        ast_dif_t [AST_ALERTS-1:0] alerts;
    } ast_alert_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACKLO = 2'd2
    } ast_alert_st_e;

endpackage

`default_nettype wire

// File: rtl/ast_alert_sender_if.sv
// ============================================================================
// Module   : ast_alert_sender_if
// Brief    : Alert request/acknowledge bundle between sender and receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ast_alert_sender_if;
    import my_pkg::*;

    ast_alert_req_t alert_req_o;
    ast_alert_rsp_t alert_rsp_i;

    modport master (output alert_req_o, input alert_rsp_i);
    modport slave  (input alert_req_o, output alert_rsp_i);
endinterface

`default_nettype wire

// File: rtl/ast_alert_sender_chan.sv
// ============================================================================
// Module   : ast_alert_sender_chan
// Brief    : One alert channel: four-phase handshake FSM, pending flag,
//            saturating merge counter; watchdog under AST_ALERT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ast_alert_sender_chan
    import my_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             trig_i,
    input  wire logic             ack_i,
    input  wire logic             clr_i,
    output logic                  req_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      cnt_o,
    output logic                  timeout_o
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    ast_alert_st_e    state_q, state_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef AST_ALERT_TIMEOUT_EN
    localparam int c_tmr_w = $clog2(TIMEOUT_CYC);
    logic [c_tmr_w-1:0] tmr_q, tmr_d;
    logic               to_q, to_d;
`endif

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
`ifdef AST_ALERT_TIMEOUT_EN
        tmr_d     = tmr_q;
        to_d      = to_q;
`endif
        case (state_q)
            IDLE:    if (trig_i) state_d = REQ;
            REQ:     if (ack_i) state_d = ACKLO;
            ACKLO:   if (!ack_i) state_d = (pending_q || trig_i) ? REQ : IDLE;
            default: state_d = IDLE;
        endcase

        // Events during a handshake: first one queues, further ones are counted.
        if (trig_i && (state_q != IDLE)) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (cnt_q != c_cnt_max) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if ((state_q == ACKLO) && !ack_i) pending_d = 1'b0;

`ifdef AST_ALERT_TIMEOUT_EN
        if ((state_q != IDLE) && (state_d == state_q) &&
            (tmr_q == c_tmr_w'(TIMEOUT_CYC - 2))) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            to_d      = 1'b1;
        end
        if ((state_d != state_q) || (state_q == IDLE)) tmr_d = '0;
        else                                           tmr_d = tmr_q + c_tmr_w'(1);
        if (clr_i) to_d = 1'b0;
`endif
        if (clr_i) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef AST_ALERT_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmr_q <= '0;
            to_q  <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            to_q  <= to_d;
        end
    end
    assign timeout_o = to_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign req_o  = (state_q == REQ);
    assign busy_o = (state_q != IDLE);
    assign cnt_o  = cnt_q;

endmodule

`default_nettype wire

// File: rtl/ast_alert_sender.sv
// ============================================================================
// Module   : ast_alert_sender
// Brief    : AST alert request endpoint; one handshake channel per alert.
//            Optional watchdog enabled by AST_ALERT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ast_alert_sender
    import my_pkg::*;
#(
    parameter int N_ALERTS    = 2,
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  wire logic                      clk_i,
    input  wire logic                      rst_i,
    input  wire logic [N_ALERTS-1:0]       trig_i,
    input  wire logic                      clr_i,
    ast_alert_sender_if.master             alert_if,
    output logic [N_ALERTS-1:0]            busy_o,
    output logic [N_ALERTS*CNT_W-1:0]      merged_cnt_o,
    output logic [N_ALERTS-1:0]            timeout_o
);

    logic [N_ALERTS-1:0] w_req;
    ast_alert_req_t      w_alert_req;

    generate
        for (genvar k = 0; k < N_ALERTS; k++) begin : g_chan
            ast_alert_sender_chan #(
                .CNT_W       (CNT_W),
                .TIMEOUT_CYC (TIMEOUT_CYC)
            ) u_chan (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .trig_i    (trig_i[k]),
                .ack_i     (alert_if.alert_rsp_i.alerts_ack[k].p),
                .clr_i     (clr_i),
                .req_o     (w_req[k]),
                .busy_o    (busy_o[k]),
                .cnt_o     (merged_cnt_o[k*CNT_W +: CNT_W]),
                .timeout_o (timeout_o[k])
            );
        end
    endgenerate

    always_comb begin
        w_alert_req = '0;
        for (int k = 0; k < N_ALERTS; k++) begin
            w_alert_req.alerts[k].p = w_req[k];
        end
    end

    assign alert_if.alert_req_o = w_alert_req;

endmodule

`default_nettype wire
